dht11_sched: RTL and testbench

DHT11_SCHED -- requirements
Module: dht11_sched

---
 rtl/dht11_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_dht11_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sched.sv
// DHT11 measurement scheduler: periodic/forced starts, timeout, error count, stale tracking.
// Define DHT11_SCHED_RETRY_EN to retry a failed read after a 1100 ms backoff.
module dht11_sched #(
  parameter int CLK_HZ     = 125_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 50,
  parameter int MAX_RETRY  = 3,
  parameter int STALE_MS   = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       force_req,
  output logic       meas_start,
  input  logic       meas_done,
  input  logic       meas_ok,
  input  logic [7:0] humi_in,
  input  logic [7:0] temp_in,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       stale,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(PERIOD_MS + 1);
`ifdef DHT11_SCHED_RETRY_EN
  localparam int BACKOFF_MS = 1100;
  localparam int TMAX       = (TIMEOUT_MS > BACKOFF_MS) ? TIMEOUT_MS : BACKOFF_MS;
  localparam int RW         = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
`else
  localparam int TMAX       = TIMEOUT_MS;
`endif
  localparam int TW = $clog2(TMAX + 1);
  localparam int AW = (STALE_MS < 1) ? 1 : $clog2(STALE_MS + 1);

  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_MS - 1);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_MS - 1);
`ifdef DHT11_SCHED_RETRY_EN
  localparam logic [TW-1:0] BOFF_LAST   = TW'(BACKOFF_MS - 1);
`endif
  localparam logic [AW-1:0] STALE_MAX   = AW'(STALE_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  state_t        state_r;
  logic [DW-1:0] presc_r;
  logic [PW-1:0] period_r;
  logic [TW-1:0] tmr_r;
  logic [AW-1:0] age_r;
  logic [AW-1:0] age_nxt_s;
`ifdef DHT11_SCHED_RETRY_EN
  logic [RW-1:0] retry_r;
`endif
  logic          force_d_r;
  logic          tick_s;
  logic          force_rise_s;
  logic          capture_s;
  logic          fail_s;
  logic          valid_nxt_s;
  logic          stale_nxt_s;
  logic          meas_start_r;
  logic          busy_r;
  logic [7:0]    humidity_r;
  logic [7:0]    temperature_r;
  logic          data_valid_r;
  logic          stale_r;
  logic [7:0]    err_cnt_r;

  assign tick_s       = (presc_r == DIV_LAST);
  assign force_rise_s = force_req & ~force_d_r;
  assign capture_s    = (state_r == WAIT) & meas_done & meas_ok;

  // A failure is a bad checksum, or a timeout on a cycle without meas_done
  always_comb begin
    fail_s = 1'b0;
    if (state_r == WAIT) begin
      if (meas_done) begin
        fail_s = ~meas_ok;
      end else begin
        fail_s = tick_s & (tmr_r == TOUT_LAST);
      end
    end else begin
      fail_s = 1'b0;
    end
  end

  // Next age and validity, so stale can be registered alongside them
  always_comb begin
    age_nxt_s = age_r;
    if (capture_s) begin
      age_nxt_s = {AW{1'b0}};
    end else if (tick_s && (age_r != STALE_MAX)) begin
      age_nxt_s = age_r + AW'(1'b1);
    end else begin
      age_nxt_s = age_r;
    end
    valid_nxt_s = data_valid_r | capture_s;
    stale_nxt_s = (age_nxt_s == STALE_MAX) | ~valid_nxt_s;
  end

  // Scheduler FSM; one timer serves both the result timeout and the backoff
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      period_r     <= {PW{1'b0}};
      tmr_r        <= {TW{1'b0}};
      meas_start_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef DHT11_SCHED_RETRY_EN
      retry_r      <= {RW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (force_rise_s || (tick_s && (period_r == PERIOD_LAST))) begin
            state_r      <= START;
            period_r     <= {PW{1'b0}};
            meas_start_r <= 1'b1;
            busy_r       <= 1'b1;
          end else begin
            meas_start_r <= 1'b0;
            busy_r       <= 1'b0;
            if (tick_s) begin
              period_r <= period_r + PW'(1'b1);
            end
          end
        end
        START: begin
          state_r      <= WAIT;
          tmr_r        <= {TW{1'b0}};
          meas_start_r <= 1'b0;
          busy_r       <= 1'b1;
        end
        WAIT: begin
          meas_start_r <= 1'b0;
          if (capture_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
`ifdef DHT11_SCHED_RETRY_EN
            retry_r <= {RW{1'b0}};
`endif
          end else if (fail_s) begin
`ifdef DHT11_SCHED_RETRY_EN
            if (retry_r < RETRY_MAX) begin
              state_r <= BACKOFF;
              tmr_r   <= {TW{1'b0}};
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              retry_r <= {RW{1'b0}};
              busy_r  <= 1'b0;
            end
`else
            state_r <= IDLE;
            busy_r  <= 1'b0;
`endif
          end else if (tick_s) begin
            tmr_r <= tmr_r + TW'(1'b1);
          end
        end
        BACKOFF: begin
`ifdef DHT11_SCHED_RETRY_EN
          if (tick_s && (tmr_r == BOFF_LAST)) begin
            state_r      <= START;
            retry_r      <= retry_r + RW'(1'b1);
            meas_start_r <= 1'b1;
          end else begin
            meas_start_r <= 1'b0;
            if (tick_s) begin
              tmr_r <= tmr_r + TW'(1'b1);
            end
          end
          busy_r <= 1'b1;
`else
          state_r      <= IDLE;
          meas_start_r <= 1'b0;
          busy_r       <= 1'b0;
`endif
        end
        default: begin
          state_r      <= IDLE;
          meas_start_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler, edge detect, captured reading, age/stale and error counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r       <= {DW{1'b0}};
      force_d_r     <= 1'b0;
      age_r         <= {AW{1'b0}};
      humidity_r    <= 8'h00;
      temperature_r <= 8'h00;
      data_valid_r  <= 1'b0;
      stale_r       <= 1'b1;
      err_cnt_r     <= 8'h00;
    end else begin
      presc_r      <= tick_s ? {DW{1'b0}} : (presc_r + DW'(1'b1));
      force_d_r    <= force_req;
      age_r        <= age_nxt_s;
      data_valid_r <= valid_nxt_s;
      stale_r      <= stale_nxt_s;
      if (capture_s) begin
        humidity_r    <= humi_in;
        temperature_r <= temp_in;
      end
      if (fail_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign meas_start  = meas_start_r;
  assign busy        = busy_r;
  assign humidity    = humidity_r;
  assign temperature = temperature_r;
  assign data_valid  = data_valid_r;
  assign stale       = stale_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_dht11_sched.sv
// Self-checking bench for dht11_sched: directed vector table, hand-written corner
// sequences, then random stimulus against a timestamp-based reference model.
module tb_dht11_sched;

  localparam int PERIOD  = 5;
  localparam int TIMEOUT = 3;
  localparam int MAXR    = 2;
  localparam int STALE   = 20;
  localparam int BACKOFF = 1100;
`ifdef DHT11_SCHED_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif
  localparam int FAIL_COST   = RETRY ? (MAXR + 1) : 1;
  localparam int RAND_CYCLES = 3000;

  localparam int MD_IDLE = 0, MD_START = 1, MD_WAIT = 2, MD_BACKOFF = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       force_req;
  logic       meas_start;
  logic       meas_done;
  logic       meas_ok;
  logic [7:0] humi_in;
  logic [7:0] temp_in;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       data_valid;
  logic       stale;
  logic [7:0] err_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  dht11_sched #(
    .CLK_HZ(1000), .PERIOD_MS(PERIOD), .TIMEOUT_MS(TIMEOUT),
    .MAX_RETRY(MAXR), .STALE_MS(STALE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .force_req(force_req), .meas_start(meas_start),
    .meas_done(meas_done), .meas_ok(meas_ok), .humi_in(humi_in), .temp_in(temp_in),
    .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
    .stale(stale), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ok;
    logic [7:0] humi;
    logic [7:0] temp;
    int         delay;
    logic [7:0] exp_hum;
    logic [7:0] exp_temp;
    bit         exp_fail;
  } vec_t;

  vec_t vecs [6];

  // Reference model state: event timestamps in clock edges since reset release
  int         k, m_mode, m_idle_since, m_wait_from, m_boff_from, m_retry, m_err, m_last_good;
  bit         m_valid, m_start, m_force_prev;
  logic [7:0] m_hum, m_temp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      cyc();
      n++;
    end
    chk("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    k = 0; m_mode = MD_IDLE; m_idle_since = 0; m_wait_from = 0; m_boff_from = 0;
    m_retry = 0; m_err = 0; m_last_good = 0; m_valid = 0; m_start = 0;
    m_force_prev = 0; m_hum = 8'h00; m_temp = 8'h00;
  endtask

  task automatic model_fail();
    m_err = sat8(m_err + 1);
    if (RETRY != 0 && m_retry < MAXR) begin
      m_mode = MD_BACKOFF;
      m_boff_from = k;
    end else begin
      m_retry = 0;
      m_mode = MD_IDLE;
      m_idle_since = k;
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled
  task automatic model_step();
    bit rise;
    k++;
    rise = force_req && !m_force_prev;
    m_force_prev = force_req;
    m_start = 1'b0;
    case (m_mode)
      MD_IDLE:
        if (rise || (k - m_idle_since == PERIOD)) begin
          m_mode = MD_START;
          m_start = 1'b1;
        end
      MD_START: begin
        m_mode = MD_WAIT;
        m_wait_from = k;
      end
      MD_WAIT:
        if (meas_done && meas_ok) begin
          m_hum = humi_in; m_temp = temp_in; m_valid = 1'b1; m_last_good = k;
          m_retry = 0; m_mode = MD_IDLE; m_idle_since = k;
        end else if (meas_done || (k - m_wait_from == TIMEOUT)) begin
          model_fail();
        end
      MD_BACKOFF:
        if (k - m_boff_from == BACKOFF) begin
          m_retry++;
          m_mode = MD_START;
          m_start = 1'b1;
        end
      default: m_mode = MD_IDLE;
    endcase
  endtask

  initial begin
    int n, exp_err, pulses;

    vecs[0] = '{ok: 1'b1, humi: 8'h40, temp: 8'h1A, delay: 1, exp_hum: 8'h40, exp_temp: 8'h1A, exp_fail: 1'b0};
    vecs[1] = '{ok: 1'b0, humi: 8'hFF, temp: 8'hFF, delay: 2, exp_hum: 8'h40, exp_temp: 8'h1A, exp_fail: 1'b1};
    vecs[2] = '{ok: 1'b1, humi: 8'h00, temp: 8'h00, delay: 3, exp_hum: 8'h00, exp_temp: 8'h00, exp_fail: 1'b0};
    vecs[3] = '{ok: 1'b1, humi: 8'hFF, temp: 8'hFF, delay: 2, exp_hum: 8'hFF, exp_temp: 8'hFF, exp_fail: 1'b0};
    vecs[4] = '{ok: 1'b0, humi: 8'h12, temp: 8'h34, delay: 3, exp_hum: 8'hFF, exp_temp: 8'hFF, exp_fail: 1'b1};
    vecs[5] = '{ok: 1'b1, humi: 8'h2D, temp: 8'h18, delay: 1, exp_hum: 8'h2D, exp_temp: 8'h18, exp_fail: 1'b0};

    reset_n = 1'b0; force_req = 1'b0; meas_done = 1'b0; meas_ok = 1'b0;
    humi_in = 8'h00; temp_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_meas_start", 32'(meas_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_stale", 32'(stale), 32'd1);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_hum", 32'(humidity), 32'd0);
    chk("rst_temp", 32'(temperature), 32'd0);

    // First automatic measurement PERIOD ticks after release
    reset_n = 1'b1;
    n = 0;
    while (!meas_start && n < 10) begin
      cyc();
      n++;
    end
    chk("first_start_cycle_4to6", 32'(n >= 4 && n <= 6), 32'd1);
    chk("first_start_stale", 32'(stale), 32'd1);
    chk("first_start_valid", 32'(data_valid), 32'd0);
    cyc();
    chk("start_one_cycle", 32'(meas_start), 32'd0);
    meas_done = 1'b1; meas_ok = 1'b1; humi_in = 8'h2D; temp_in = 8'h18;
    cyc();
    meas_done = 1'b0; meas_ok = 1'b0;
    chk("good_hum", 32'(humidity), 32'h2D);
    chk("good_temp", 32'(temperature), 32'h18);
    chk("good_valid", 32'(data_valid), 32'd1);
    chk("good_stale", 32'(stale), 32'd0);
    chk("good_busy", 32'(busy), 32'd0);
    exp_err = 0;

    // Table: forced start, result after 'delay' cycles (3 = same edge as timeout)
    for (int i = 0; i < 6; i++) begin
      force_req = 1'b1;
      cyc();
      chk("vec_force_start", 32'(meas_start), 32'd1);
      force_req = 1'b0;
      for (int j = 0; j < vecs[i].delay; j++) cyc();
      meas_done = 1'b1; meas_ok = vecs[i].ok; humi_in = vecs[i].humi; temp_in = vecs[i].temp;
      cyc();
      meas_done = 1'b0; meas_ok = 1'b0;
      if (vecs[i].exp_fail) exp_err = sat8(exp_err + 1);
      chk("vec_hum", 32'(humidity), 32'(vecs[i].exp_hum));
      chk("vec_temp", 32'(temperature), 32'(vecs[i].exp_temp));
      chk("vec_valid", 32'(data_valid), 32'd1);
      chk("vec_stale", 32'(stale), 32'd0);
      chk("vec_err", 32'(err_cnt), 32'(exp_err));
      chk("vec_busy", 32'(busy), vecs[i].exp_fail ? 32'(RETRY) : 32'd0);
      if (vecs[i].exp_fail) begin
        wait_idle();
        exp_err = sat8(exp_err + FAIL_COST - 1);
        chk("vec_err_after_retries", 32'(err_cnt), 32'(exp_err));
      end
    end

    // meas_done during START ignored; force edge during WAIT ignored; timeout edge
    force_req = 1'b1;
    cyc();
    chk("seq_force_start", 32'(meas_start), 32'd1);
    force_req = 1'b0;
    meas_done = 1'b1; meas_ok = 1'b1; humi_in = 8'h77; temp_in = 8'h66;
    cyc();
    meas_done = 1'b0; meas_ok = 1'b0;
    chk("start_done_ignored_hum", 32'(humidity), 32'h2D);
    chk("start_done_ignored_err", 32'(err_cnt), 32'(exp_err));
    pulses = 32'(meas_start);
    force_req = 1'b1;
    cyc();
    pulses += 32'(meas_start);
    cyc();
    pulses += 32'(meas_start);
    chk("no_early_timeout_err", 32'(err_cnt), 32'(exp_err));
    chk("no_early_timeout_busy", 32'(busy), 32'd1);
    cyc();
    pulses += 32'(meas_start);
    exp_err = sat8(exp_err + 1);
    chk("timeout_err", 32'(err_cnt), 32'(exp_err));
    chk("timeout_busy", 32'(busy), 32'(RETRY));
    chk("wait_force_no_pulse", 32'(pulses), 32'd0);
    chk("timeout_hum_hold", 32'(humidity), 32'h2D);
    wait_idle();
    exp_err = sat8(exp_err + FAIL_COST - 1);
    chk("timeout_err_final", 32'(err_cnt), 32'(exp_err));
    cyc();
    chk("not_queued_1", 32'(meas_start), 32'd0);
    cyc();
    chk("not_queued_2", 32'(meas_start), 32'd0);
    force_req = 1'b0;
    meas_done = 1'b1; meas_ok = 1'b1; humi_in = 8'h99; temp_in = 8'h99;
    cyc();
    meas_done = 1'b0; meas_ok = 1'b0;
    chk("idle_done_hum", 32'(humidity), 32'h2D);
    chk("idle_done_err", 32'(err_cnt), 32'(exp_err));
    chk("idle_done_busy", 32'(busy), 32'd0);

    // Good read, then STALE ticks without another good read
    force_req = 1'b1;
    cyc();
    force_req = 1'b0;
    cyc();
    meas_done = 1'b1; meas_ok = 1'b1; humi_in = 8'h55; temp_in = 8'h66;
    cyc();
    meas_done = 1'b0; meas_ok = 1'b0;
    chk("stale_setup_hum", 32'(humidity), 32'h55);
    repeat (STALE - 1) cyc();
    chk("stale_not_yet", 32'(stale), 32'd0);
    cyc();
    chk("stale_set", 32'(stale), 32'd1);
    chk("stale_hum_hold", 32'(humidity), 32'h55);
    chk("stale_temp_hold", 32'(temperature), 32'h66);
    chk("stale_valid_hold", 32'(data_valid), 32'd1);

    // Asynchronous reset in the middle of WAIT
    wait_idle();
    force_req = 1'b1;
    cyc();
    force_req = 1'b0;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_hum", 32'(humidity), 32'd0);
    chk("mid_rst_temp", 32'(temperature), 32'd0);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_stale", 32'(stale), 32'd1);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(meas_start), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    meas_done = 1'b1; meas_ok = 1'b1; humi_in = 8'hAB; temp_in = 8'hAB;
    cyc();
    meas_done = 1'b0; meas_ok = 1'b0;
    chk("post_rst_done_hum", 32'(humidity), 32'd0);
    chk("post_rst_done_valid", 32'(data_valid), 32'd0);
    chk("post_rst_done_err", 32'(err_cnt), 32'd0);

    // Random stimulus against the reference model
    reset_n = 1'b0; force_req = 1'b0; meas_done = 1'b0;
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if ($urandom_range(7, 0) == 0) force_req = ~force_req;
      meas_done = !meas_done && ($urandom_range(5, 0) == 0);
      meas_ok   = ($urandom_range(1, 0) == 1);
      humi_in   = 8'($urandom);
      temp_in   = 8'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rand_meas_start", 32'(meas_start), 32'(m_start));
      chk("rand_busy", 32'(busy), 32'(m_mode != MD_IDLE));
      chk("rand_hum", 32'(humidity), 32'(m_hum));
      chk("rand_temp", 32'(temperature), 32'(m_temp));
      chk("rand_valid", 32'(data_valid), 32'(m_valid));
      chk("rand_stale", 32'(stale), 32'(!m_valid || (k - m_last_good >= STALE)));
      chk("rand_err", 32'(err_cnt), 32'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
